paddle_scan_ctrl: RTL

Sequences the shared paddle one-shot trigger (PAD_TRG_N) once per frame and measures the resulting PAD1/PAD2 one-shot pulse widths as digital paddle positions.
- Sits between the input synchronizers and pongtop, in the CLK_DRV domain.
- Replaces free-running analog trigger timing with a deterministic trigger/measure/latch cycle.
- Provides registered positions, timeout flags and a valid strobe.

---
 rtl/paddle_scan_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/paddle_scan_ctrl.sv
// Paddle scan controller: fires the shared one-shot trigger once per frame,
// then measures the PAD1/PAD2 pulse widths in prescaled ticks and latches them.
module paddle_scan_ctrl #(
  parameter int TRG_WIDTH = 8,
  parameter int PRESCALE  = 14,
  parameter int CNT_W     = 8,
  parameter int MAX_COUNT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             pad1_in,
  input  logic             pad2_in,
  output logic             pad_trg_n,
  output logic [CNT_W-1:0] pad1_pos,
  output logic [CNT_W-1:0] pad2_pos,
  output logic             pad1_timeout,
  output logic             pad2_timeout,
  output logic             pos_valid,
  output logic             busy
);

  localparam int TRG_W = (TRG_WIDTH > 1) ? $clog2(TRG_WIDTH) : 1;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [TRG_W-1:0] TRG_LAST = TRG_W'(TRG_WIDTH - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);

  typedef enum logic [1:0] {IDLE, TRIG, MEASURE, DONE} state_e;

  state_e           state_q, state_d;
  logic [TRG_W-1:0] trg_cnt_q, trg_cnt_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic             done1_q, done1_d, done2_q, done2_d;
  logic             trg_n_q, trg_n_d;
  logic [CNT_W-1:0] pos1_q, pos1_d, pos2_q, pos2_d;
  logic             to1_q, to1_d, to2_q, to2_d;
  logic             valid_q, valid_d;
  logic             tick;

  // NOTE: every variable gets a default first so no path can leave one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    trg_cnt_d  = trg_cnt_q;
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    done1_d    = done1_q;
    done2_d    = done2_q;
    trg_n_d    = trg_n_q;
    pos1_d     = pos1_q;
    pos2_d     = pos2_q;
    to1_d      = to1_q;
    to2_d      = to2_q;
    valid_d    = 1'b0;
    tick       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = TRIG;
          trg_n_d    = 1'b0;
          trg_cnt_d  = '0;
          tick_cnt_d = '0;
          cnt1_d     = '0;
          cnt2_d     = '0;
          done1_d    = 1'b0;
          done2_d    = 1'b0;
        end
      end
      TRIG: begin
        if (trg_cnt_q == TRG_LAST) begin
          state_d = MEASURE;
          trg_n_d = 1'b1;
          presc_d = '0;
        end else begin
          trg_cnt_d = trg_cnt_q + 1'b1;
        end
      end
      MEASURE: begin
        tick    = (presc_q == PRE_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick && tick_cnt_q != CNT_MAX) tick_cnt_d = tick_cnt_q + 1'b1;
        // A falling input wins over a coincident tick: the channel closes uncounted.
        if (!done1_q) begin
          if (!pad1_in)                         done1_d = 1'b1;
          else if (tick && cnt1_q != CNT_MAX)   cnt1_d  = cnt1_q + 1'b1;
        end
        if (!done2_q) begin
          if (!pad2_in)                         done2_d = 1'b1;
          else if (tick && cnt2_q != CNT_MAX)   cnt2_d  = cnt2_q + 1'b1;
        end
        if ((done1_d && done2_d) || tick_cnt_d == CNT_MAX) state_d = DONE;
      end
      DONE: begin
        pos1_d  = cnt1_q;
        pos2_d  = cnt2_q;
        to1_d   = !done1_q;
        to2_d   = !done2_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      trg_cnt_q  <= '0;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      done1_q    <= 1'b0;
      done2_q    <= 1'b0;
      trg_n_q    <= 1'b1;
      pos1_q     <= '0;
      pos2_q     <= '0;
      to1_q      <= 1'b0;
      to2_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      trg_cnt_q  <= trg_cnt_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      done1_q    <= done1_d;
      done2_q    <= done2_d;
      trg_n_q    <= trg_n_d;
      pos1_q     <= pos1_d;
      pos2_q     <= pos2_d;
      to1_q      <= to1_d;
      to2_q      <= to2_d;
      valid_q    <= valid_d;
    end
  end

  assign pad_trg_n    = trg_n_q;
  assign pad1_pos     = pos1_q;
  assign pad2_pos     = pos2_q;
  assign pad1_timeout = to1_q;
  assign pad2_timeout = to2_q;
  assign pos_valid    = valid_q;
  assign busy         = (state_q != IDLE);

endmodule
